// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-ported word-addressed data memory.
// Port 0 has fixed priority; port 1 is forced through after MAX_WAIT consecutive denials.

module dm_arb_rsp (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt,
  input  logic        we,
  input  logic        in_range,
  input  logic [31:0] mem_rd,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  logic [1:0] vld_pipe;

  assign vld_pipe[0] = gnt;
  assign rvalid      = vld_pipe[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      rdata       <= '0;
      err         <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      // rdata/err only move on a response for this port, otherwise they hold
      if (gnt) begin
        rdata <= (!we && in_range) ? mem_rd : '0;
        err   <= !in_range;
      end
    end
  end
endmodule

module dm_arbiter #(
  parameter int MEM_WORDS = 3072,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [2:0]  p1_wait
);
  localparam int          NUM_PORTS = 2;
  localparam logic [31:0] WORDS     = 32'(MEM_WORDS);
  localparam logic [2:0]  MAXW      = 3'(MAX_WAIT);

  logic [NUM_PORTS-1:0]         req, we, gnt, in_range, rvalid, err;
  logic [NUM_PORTS-1:0][31:0]   addr, wdata, rdata;
  logic                         force1, sel;

  assign req   = {p1_req, p0_req};
  assign we    = {p1_we, p0_we};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  // Full-width word compare so high address bits can never alias into range
  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_port
      assign in_range[g] = {2'b00, addr[g][31:2]} < WORDS;

      dm_arb_rsp u_rsp (
        .clk      (clk),
        .reset    (reset),
        .gnt      (gnt[g]),
        .we       (we[g]),
        .in_range (in_range[g]),
        .mem_rd   (mem_rd),
        .rvalid   (rvalid[g]),
        .rdata    (rdata[g]),
        .err      (err[g])
      );
    end
  endgenerate

  assign force1 = p1_req && (p1_wait == MAXW);

  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (force1)      gnt[1] = 1'b1;
      else if (p0_req) gnt[0] = 1'b1;
      else if (p1_req) gnt[1] = 1'b1;
    end
  end

  assign sel = gnt[1];

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (|gnt) begin
      mem_we   = we[sel] && in_range[sel];
      mem_addr = {addr[sel][31:2], 2'b00};
      mem_wd   = wdata[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !p1_req || p1_gnt) p1_wait <= '0;
    else if (p1_wait != MAXW)       p1_wait <= p1_wait + 3'd1;
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign p0_err    = err[0];
  assign p1_err    = err[1];
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 3072-word memory.

module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [2:0]  p1_wait;
  logic        fill;
  logic [31:0] mem [0:3071];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_WORDS(3072), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .p1_wait(p1_wait)
  );

  // Memory preloaded with 0xA500_0000 | word index
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 3072; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (mem_we && mem_addr[31:2] < 30'd3072) begin
      mem[int'(mem_addr[13:2])] <= mem_wd;
    end
  end

  always_comb begin
    mem_rd = 32'hBAD0_BAD0;
    if (mem_addr[31:2] < 30'd3072) mem_rd = mem[int'(mem_addr[13:2])];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fill = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    cyc();
    fill = 1'b0;

    // Requests during reset are ignored
    p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'h1111_2222;
    p1_req = 1; p1_addr = 32'h4;
    #1;
    chk("rst_gnt0", p0_gnt, 0);
    chk("rst_gnt1", p1_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    cyc();
    chk("rst_rvalid0", p0_rvalid, 0);
    chk("rst_rvalid1", p1_rvalid, 0);
    chk("rst_rdata0", p0_rdata, 0);
    chk("rst_err0", p0_err, 0);
    chk("rst_wait", p1_wait, 0);
    chk("rst_nowrite", mem[8], 32'hA500_0008);
    reset = 0; p0_req = 0; p0_we = 0; p1_req = 0;
    cyc();

    // Port 0 write then read back
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt0", p0_gnt, 1);
    chk("wr_gnt1", p1_gnt, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
    cyc();
    chk("wr_rvalid", p0_rvalid, 1);
    chk("wr_rdata", p0_rdata, 0);
    chk("wr_err", p0_err, 0);
    p0_we = 0;
    #1;
    chk("rd_gnt0", p0_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    cyc();
    chk("rd_rvalid", p0_rvalid, 1);
    chk("rd_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("rd_err", p0_err, 0);
    p0_req = 0;
    cyc();
    chk("idle_rvalid", p0_rvalid, 0);
    chk("idle_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

    // Misaligned read lands on word 4
    p0_req = 1; p0_addr = 32'h13;
    #1;
    chk("mis_mem_addr", mem_addr, 32'h10);
    cyc();
    chk("mis_rdata", p0_rdata, 32'hDEAD_BEEF);
    p0_req = 0;

    // Port 1 at the last legal word, then just past the end
    p1_req = 1; p1_we = 0; p1_addr = 32'h2FFC;
    #1;
    chk("p1_last_gnt", p1_gnt, 1);
    chk("p1_last_mem_addr", mem_addr, 32'h2FFC);
    cyc();
    chk("p1_last_rvalid", p1_rvalid, 1);
    chk("p1_last_rdata", p1_rdata, 32'hA500_0BFF);
    chk("p1_last_err", p1_err, 0);
    chk("p0_rvalid_quiet", p0_rvalid, 0);
    p1_we = 1; p1_addr = 32'h3000; p1_wdata = 32'h1234_5678;
    #1;
    chk("p1_oor_gnt", p1_gnt, 1);
    chk("p1_oor_mem_we", mem_we, 0);
    cyc();
    chk("p1_oor_rvalid", p1_rvalid, 1);
    chk("p1_oor_err", p1_err, 1);
    chk("p1_oor_rdata", p1_rdata, 0);
    // Address that aliases word 0 in the low bits must not write word 0
    p1_addr = 32'hC000;
    #1;
    chk("p1_alias_mem_we", mem_we, 0);
    cyc();
    p1_addr = 32'h8000_0000;
    #1;
    chk("p1_high_mem_we", mem_we, 0);
    cyc();
    chk("p1_high_err", p1_err, 1);
    p1_we = 0; p1_addr = 32'h3000;
    cyc();
    chk("p1_oor_rd_err", p1_err, 1);
    chk("p1_oor_rd_rdata", p1_rdata, 0);
    p1_addr = 32'h0;
    cyc();
    chk("p1_word0_intact", p1_rdata, 32'hA500_0000);
    chk("p1_word0_err", p1_err, 0);
    p1_req = 0;
    cyc();

    // Both held continuously: P0 x4 then forced P1
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        chk($sformatf("starve_rv1_%0d", k), p1_rvalid, ((k - 1) % 5 == 4) ? 1 : 0);
        chk($sformatf("starve_rv0_%0d", k), p0_rvalid, ((k - 1) % 5 == 4) ? 0 : 1);
      end
      #1;
      chk($sformatf("starve_wait_%0d", k), p1_wait, k % 5);
      chk($sformatf("starve_gnt1_%0d", k), p1_gnt, (k % 5 == 4) ? 1 : 0);
      chk($sformatf("starve_gnt0_%0d", k), p0_gnt, (k % 5 == 4) ? 0 : 1);
      chk($sformatf("starve_addr_%0d", k), mem_addr, (k % 5 == 4) ? 32'h4 : 32'h0);
      cyc();
    end
    chk("starve_p1_rdata", p1_rdata, 32'hA500_0001);

    // Drop p1_req at wait=3: counter restarts, port 0 keeps priority 4 more cycles
    repeat (3) cyc();
    chk("drop_wait3", p1_wait, 3);
    p1_req = 0;
    cyc();
    chk("drop_wait0", p1_wait, 0);
    p1_req = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("reassert_gnt1_%0d", k), p1_gnt, (k == 4) ? 1 : 0);
      cyc();
    end
    p0_req = 0; p1_req = 0;
    cyc();

    // Reset in the cycle after a port 0 read grant
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    p1_req = 1;
    cyc();
    chk("mid_pre_rvalid", p0_rvalid, 1);
    chk("mid_pre_wait", p1_wait, 1);
    reset = 1;
    #1;
    chk("mid_rst_gnt0", p0_gnt, 0);
    chk("mid_rst_gnt1", p1_gnt, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    cyc();
    chk("mid_rvalid", p0_rvalid, 0);
    chk("mid_rdata", p0_rdata, 0);
    chk("mid_wait", p1_wait, 0);
    reset = 0; p0_req = 0; p1_req = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
